// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller, single-word CPU port, line-wide memory port.
// Optional hit/miss counters are built in when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
    parameter int NUM_SETS   = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     is_input_valid,
    input  logic [31:0]              addr,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [31:0]              din,
    output logic                     is_ready,
    output logic                     is_output_valid,
    output logic [31:0]              dout,
    output logic                     is_hit,
    input  logic                     mem_is_ready,
    output logic                     mem_is_input_valid,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [31:0]              mem_addr,
    output logic [32*LINE_WORDS-1:0] mem_din,
    input  logic [32*LINE_WORDS-1:0] mem_dout,
`ifdef DCACHE_STATS_EN
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count,
`endif
    input  logic                     mem_is_output_valid
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;
    localparam int LINE_W = 32 * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic              wr_q, wr_d;
    logic              miss_q, miss_d;
    logic              fill_sent_q, fill_sent_d;

    logic              valid_q [NUM_SETS];
    logic              dirty_q [NUM_SETS];
    logic [TAG_W-1:0]  tag_q   [NUM_SETS];
    logic [LINE_W-1:0] data_q  [NUM_SETS];

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              lookup_hit;
    logic              store_we;
    logic              fill_we;
    logic              unused_byte_bits;

    assign req_off          = addr_q[2 +: OFF_W];
    assign req_idx          = addr_q[2 + OFF_W +: IDX_W];
    assign req_tag          = addr_q[31 -: TAG_W];
    assign lookup_hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_byte_bits = ^addr_q[1:0];

    // is_ready is gated by reset so it reads 0 while reset is held.
    assign is_ready = reset && (state_q == IDLE);
    assign is_hit   = is_output_valid && !miss_q;

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        din_d              = din_q;
        wr_d               = wr_q;
        miss_d             = miss_q;
        fill_sent_d        = fill_sent_q;
        is_output_valid    = 1'b0;
        dout               = '0;
        mem_is_input_valid = 1'b0;
        mem_rd             = 1'b0;
        mem_wr             = 1'b0;
        mem_addr           = '0;
        mem_din            = '0;
        store_we           = 1'b0;
        fill_we            = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_input_valid && (mem_read ^ mem_write)) begin
                    addr_d  = addr;
                    din_d   = din;
                    wr_d    = mem_write;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (lookup_hit) begin
                    is_output_valid = 1'b1;
                    miss_d          = 1'b0;
                    state_d         = IDLE;
                    if (wr_q) store_we = 1'b1;
                    else      dout     = data_q[req_idx][{req_off, 5'b0} +: 32];
                end else begin
                    miss_d      = 1'b1;
                    fill_sent_d = 1'b0;
                    state_d     = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_is_input_valid = 1'b1;
                mem_wr             = 1'b1;
                mem_addr           = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}, 2'b00};
                mem_din            = data_q[req_idx];
                if (mem_is_ready) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                // The fill request is withdrawn once accepted; the line arrives later as a pulse.
                if (!fill_sent_q) begin
                    mem_is_input_valid = 1'b1;
                    mem_rd             = 1'b1;
                    mem_addr           = {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                    if (mem_is_ready) fill_sent_d = 1'b1;
                end
                if (mem_is_output_valid) begin
                    fill_we = 1'b1;
                    state_d = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            din_q       <= '0;
            wr_q        <= 1'b0;
            miss_q      <= 1'b0;
            fill_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            wr_q        <= wr_d;
            miss_q      <= miss_d;
            fill_sent_q <= fill_sent_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else begin
            if (store_we) dirty_q[req_idx] <= 1'b1;
            if (fill_we) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end
        end
    end

    // Tags and data need no reset: nothing reads them while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (store_we) data_q[req_idx][{req_off, 5'b0} +: 32] <= din_q;
        if (fill_we) begin
            data_q[req_idx] <= mem_dout;
            tag_q[req_idx]  <= req_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, miss_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (is_output_valid) begin
            if (is_hit) hit_count_q  <= hit_count_q + 32'd1;
            else        miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule
